// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, the fetch-queue entry
// layout and a small PC helper used by the fetch logic.
package cpu_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    // One fetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

    // Clears the low bits so a redirect target always lands on a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: two entries enqueued together, up to two retired in
// order from the head, with a synchronous flush that empties it in one edge.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq,
    input  fq_entry_t        enq_data0,
    input  fq_entry_t        enq_data1,
    input  logic             deq0,
    input  logic             deq1,
    output fq_entry_t        head0,
    output fq_entry_t        head1,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic             eff_deq0;
    logic             eff_deq1;

    // DEPTH is a power of two, so plain pointer arithmetic wraps for free.
    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    assign eff_deq0 = deq0 && (count_q != '0);
    assign eff_deq1 = deq1 && eff_deq0 && (count_q >= CNT_W'(2));

    always_comb begin
        count_n = count_q;
        if (enq) begin
            count_n = count_n + CNT_W'(2);
        end
        if (eff_deq0) begin
            count_n = count_n - CNT_W'(1);
        end
        if (eff_deq1) begin
            count_n = count_n - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_n;
            if (enq) begin
                tail_q <= tail_q + PTR_W'(2);
            end
            if (eff_deq1) begin
                head_q <= head_q + PTR_W'(2);
            end else if (eff_deq0) begin
                head_q <= head_p1;
            end
        end
    end

    // Entry storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (enq && !flush && !rst) begin
            mem[tail_q]  <= enq_data0;
            mem[tail_p1] <= enq_data1;
        end
    end

    assign head0 = mem[head_q];
    assign head1 = mem[head_p1];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit_dual.sv
// Dual-issue fetch stage: owns the PC, reads two consecutive words per fetch
// from a dual-port instruction memory and buffers them in a fetch queue.
module fetch_unit_dual
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr0,
    output logic [63:0] imem_addr1,
    input  logic [31:0] imem_instr0,
    input  logic [31:0] imem_instr1,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_instr0,
    output logic [31:0] out_instr1,
    output logic [63:0] out_pc0,
    output logic [63:0] out_pc1,
    input  logic        out_ready0,
    input  logic        out_ready1
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  fq_count;
    logic              fetch;
    logic              deq0;
    logic              deq1;
    fq_entry_t         enq_data0;
    fq_entry_t         enq_data1;
    fq_entry_t         head0;
    fq_entry_t         head1;

    assign imem_addr0 = pc_q;
    assign imem_addr1 = pc_q + ADDR_W'(INSTR_BYTES);

    // Free space is judged on the registered count only; entries retiring this
    // cycle do not make room for a fetch until the next one.
    assign fetch = !redirect_valid && ((CNT_W'(FQ_DEPTH) - fq_count) >= CNT_W'(2));

    // Handshake: slot X transfers on an edge where out_validX and out_readyX are
    // both high; slot 1 only transfers together with slot 0, keeping retirement
    // in program order. Valid never depends on ready.
    assign out_valid0 = (fq_count >= CNT_W'(1));
    assign out_valid1 = (fq_count >= CNT_W'(2));
    assign deq0       = out_valid0 && out_ready0;
    assign deq1       = out_valid1 && out_ready1 && deq0;

    assign enq_data0 = '{instr: imem_instr0, pc: imem_addr0};
    assign enq_data1 = '{instr: imem_instr1, pc: imem_addr1};

    assign out_instr0 = head0.instr;
    assign out_pc0    = head0.pc;
    assign out_instr1 = head1.instr;
    assign out_pc1    = head1.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
        end else if (fetch) begin
            pc_q <= pc_q + ADDR_W'(2 * INSTR_BYTES);
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .enq       (fetch),
        .enq_data0 (enq_data0),
        .enq_data1 (enq_data1),
        .deq0      (deq0),
        .deq1      (deq1),
        .head0     (head0),
        .head1     (head1),
        .count     (fq_count)
    );

endmodule

// File: doc/fetch_unit_dual.md
FETCH_UNIT_DUAL -- requirements
Module: fetch_unit_dual

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC loaded at reset.
REQ-002 Parameter FQ_DEPTH, default 4, is the fetch-queue entry count; it SHALL be a power of two and at least 2.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Port imem_addr0  output  64  is the byte address of fetch slot 0, driven to the dual-port instruction memory.
REQ-006 Port imem_addr1  output  64  is the byte address of fetch slot 1.
REQ-007 Port imem_instr0  input  32  is the word at imem_addr0, valid combinationally in the same cycle.
REQ-008 Port imem_instr1  input  32  is the word at imem_addr1, valid combinationally in the same cycle.
REQ-009 Port redirect_valid  input  1  is a branch/exception redirect request.
REQ-010 Port redirect_pc  input  64  is the redirect target PC.
REQ-011 Ports out_valid0 / out_valid1  output  1 each  indicate that issue slot 0 / slot 1 holds an instruction.
REQ-012 Ports out_instr0 / out_instr1  output  32 each  are the slot instructions.
REQ-013 Ports out_pc0 / out_pc1  output  64 each  are the slot PCs.
REQ-014 Ports out_ready0 / out_ready1  input  1 each  are decode acceptance for slot 0 / slot 1.

Function
REQ-015 imem_addr0 SHALL equal the PC register, and imem_addr1 SHALL equal PC+4, both modulo 2^64.
REQ-016 Fetch fires when the queue has at least 2 free entries at the start of the cycle and redirect_valid=0.
REQ-017 A fetch SHALL enqueue {imem_instr0, PC} then {imem_instr1, PC+4} in order, and PC SHALL become PC+8 modulo 2^64.
REQ-018 When no fetch fires, PC and the queue contents SHALL hold, except for dequeues.
REQ-019 out_valid0 SHALL be 1 iff count≥1, and out_valid1 SHALL be 1 iff count≥2.
REQ-020 The slot 0 outputs SHALL be the queue head, and the slot 1 outputs SHALL be head+1; all outputs are driven combinationally from registered state.
REQ-021 deq0 = out_valid0 & out_ready0.
REQ-022 deq1 = out_valid1 & out_ready1 & deq0; slot 1 SHALL never retire without slot 0.
REQ-023 Count SHALL update as count + 2·fetch − deq0 − deq1 in the same edge; free space SHALL be checked without dequeue bypass.
REQ-024 Head and tail pointers SHALL wrap modulo FQ_DEPTH, and count SHALL never exceed FQ_DEPTH or drop below 0.
REQ-025 redirect_valid=1 SHALL set PC to {redirect_pc[63:2], 2'b00} and set count and pointers to 0.
REQ-026 Redirect SHALL take priority over fetch and dequeue in the same cycle.
REQ-027 In the cycle after a redirect, out_valid0=out_valid1=0 and imem_addr0 SHALL equal the new PC.
REQ-028 Latency: an instruction fetched in cycle N SHALL appear on the out_ ports in cycle N+1 at the earliest.
REQ-029 Out_ values while out_validX=0 are don't-care and SHALL NOT be checked.

Reset
REQ-030 When rst=1 at an edge, PC SHALL become RESET_PC, count and pointers SHALL become 0, and out_valid0 and out_valid1 SHALL read 0 in the next cycle.
REQ-031 rst SHALL override redirect, fetch and dequeue; a reset mid-stream SHALL discard all queued entries.
REQ-032 After reset, imem_addr0 SHALL equal RESET_PC and imem_addr1 SHALL equal RESET_PC+4.
REQ-033 Queue data storage is not reset.

Structure
REQ-034 The shared package cpu_pkg SHALL hold ADDR_W=64, INSTR_W=32, INSTR_BYTES=4 and the fetch-queue entry typedef {instr, pc}.
REQ-035 The sub-module fetch_queue SHALL be a parameterised FIFO with 2-wide enqueue, 2-wide in-order dequeue, flush input and count output.
REQ-036 fetch_unit_dual SHALL hold only the PC register and the fetch/redirect control.

Verification
REQ-037 Reset with RESET_PC=0x1000 and out_ready=00 -> imem_addr0=0x1000 and imem_addr1=0x1004; queue fills to 4 after two fetches, then PC holds at 0x1010.
REQ-038 Continuous out_ready=11 with memory word k = k -> slot pairs (pc, instr) = (0x1000, 0x400), (0x1004, 0x401), then (0x1008, 0x402), (0x100C, 0x403), and so on, one pair per cycle sustained.
REQ-039 out_ready0=1, out_ready1=0 with the queue full -> one entry retires per cycle, and a fetch resumes once count≤2.
REQ-040 out_ready0=0, out_ready1=1 -> no dequeue and count unchanged.
REQ-041 Redirect to 0x2003 in the same cycle as a fetch and dequeue -> next cycle out_valid=00, PC=0x2000, and the following pair is (0x2000, 0x2004).
REQ-042 PC=0xFFFF_FFFF_FFFF_FFF8 fetch -> slot PCs 0x…FFF8 and 0x…FFFC, and the next PC wraps to 0x0.
REQ-043 rst asserted with 3 entries queued -> next cycle out_valid=00 and PC=RESET_PC.
